obstacle_one_ctrl: RTL and testbench
====================================

# obstacle_one_ctrl

Per-frame motion and life-cycle controller for one 16×16 obstacle sprite.
- Drives the sprite's origin (`x0`, `y0`) and 5-bit `ctrl` word from a processor-visible register set.
- Scrolls the obstacle right-to-left at a programmable speed, respawns it at a pseudo-random row, animates its frame id and freezes on collision.
- Sits between the MMIO bus slot and the obstacle sprite core, clocked with the video pipeline.

## Interface
Parameters:
- `H_SCREEN`, 640: spawn x (just off the right edge).
- `Y_MIN`, 400: lowest spawn row.
- `Y_SPAN_BITS`, 6: spawn row = `Y_MIN` + `lfsr[Y_SPAN_BITS-1:0]`.
- `RESPAWN_FRAMES`, 30: frames spent hidden between passes (1..255).
- `ANI_DIV`, 8: frames per animation step (power of two, ≤ 64).

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `cs` in 1: slot select.
- `write` in 1: write strobe, qualified by `cs`.
- `read` in 1: read strobe (unused, kept for slot uniformity).
- `addr` in 2: register index.
- `wr_data` in 32: write data.
- `rd_data` out 32: read data.
- `frame_tick` in 1: one-cycle pulse at start of each frame.
- `hit` in 1: level from the collision detector.
- `x0` out 11: sprite origin x.
- `y0` out 11: sprite origin y.
- `ctrl` out 5: {color[1:0], auto, sid[1:0]}.

## Operation
Registers (write: `cs & write`):
- 0 CTRL: [0] en, [4:1] speed px/frame, [6:5] color, [7] auto.
- 1 STATUS (read only): [15:0] pass_cnt, [17:16] state, [18] hit_flag.
- 2 CLEAR: any write clears hit_flag. If the written [0] is 1, pass_cnt is also cleared.
- 3 POS (read only): {y0, x0} in bits [21:0].
- `rd_data` is a combinational mux on `addr`; unused bits read 0.

LFSR:
- 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1.
- Steps every clock, never all-zero.

States (encoding IDLE=0, RESPAWN=1, RUN=2, HIT=3):
- IDLE: `x0` = 2047 (never in region). en=1 → RESPAWN with frame counter = 0.
- RESPAWN: count `frame_tick`s. On the `RESPAWN_FRAMES`-th tick:
  - `x0` ← `H_SCREEN`, `y0` ← `Y_MIN` + lfsr slice.
  - sid ← 0, go RUN.
- RUN:
  - `hit` high → HIT, set hit_flag, position frozen.
  - Else on `frame_tick`, if `x0` < speed: `x0` ← 2047, pass_cnt += 1 (saturates at 16'hFFFF), go RESPAWN with counter 0.
  - Else on `frame_tick`: `x0` ← `x0` − speed.
  - Speed 0 holds the position.
- HIT: position and sid frozen. A CLEAR write → RUN.
- en=0 from any state → IDLE next cycle with `x0` = 2047. This has priority over all other transitions.

Animation:
- In RUN with auto=1, a frame counter wraps at `ANI_DIV`. On wrap, sid increments mod 4.
- auto=0 holds sid.
- `ctrl` = {color, auto, sid}.

Boundary rules:
- `frame_tick` and `hit` in the same cycle in RUN: hit wins, no move.
- A CTRL write coincident with `frame_tick`: the motion step uses the old speed.
- CLEAR while `hit` is still high: returns to RUN, re-enters HIT next cycle.
- `x0` == speed: moves to 0, exits on the following tick.
- Arithmetic is 11-bit unsigned. Speed is zero-extended.

## Timing
- `x0`, `y0` and `ctrl` are registered. They update on the edge that samples `frame_tick`, i.e. visible the cycle after the pulse, before the first active line.
- State changes from `hit`, en or CLEAR take 1 cycle.
- Reset values:
  - `x0` = 2047, `y0` = `Y_MIN`, `ctrl` = 0.
  - state IDLE, pass_cnt = 0, hit_flag = 0.
  - CTRL = 0, lfsr = 16'hACE1.
  - `rd_data` follows the reset register contents.
- Reset asserted mid-pass returns everything to reset values asynchronously.

## Test plan
- Reset, write CTRL=0x03 (en, speed 1), give 30 ticks → RUN, `x0`=640, `y0` in 400..463. After 5 more ticks → `x0`=635.
- Speed 15, spawn at 640 → after 42 ticks `x0`=10. 43rd tick → `x0`=2047, RESPAWN, pass_cnt=1. 30 ticks later → `x0`=640.
- RUN with `x0`=600, assert `hit` together with `frame_tick` → `x0` stays 600, STATUS[17:16]=3, [18]=1. Write CLEAR with `hit` low → RUN, next tick moves.
- auto=1, ANI_DIV=8: sid steps 0→1→2→3→0 every 8 ticks. auto=0 holds sid. color=2 → `ctrl`[4:3]=2.
- Write en=0 mid-RUN → IDLE next cycle, `x0`=2047. Assert `reset` mid-RESPAWN → all outputs reset immediately, lfsr=ACE1.
- Force pass_cnt to 16'hFFFF via repeated passes (or backdoor), complete one more pass → stays 16'hFFFF. CLEAR with [0]=1 → 0.

Source files
------------

// File: rtl/obstacle_one_ctrl.sv
//==============================================================================
// Module      : obstacle_one_ctrl
// Description : Per-frame motion, respawn, animation and collision-freeze
//               controller for one 16x16 obstacle sprite, with MMIO registers.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module obstacle_one_ctrl #(
  parameter int H_SCREEN       = 640,
  parameter int Y_MIN          = 400,
  parameter int Y_SPAN_BITS    = 6,
  parameter int RESPAWN_FRAMES = 30,
  parameter int ANI_DIV        = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        write,
  input  logic        read,
  input  logic [1:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic        frame_tick,
  input  logic        hit,
  output logic [10:0] x0,
  output logic [10:0] y0,
  output logic [4:0]  ctrl
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RESPAWN = 2'd1,
    S_RUN     = 2'd2,
    S_HIT     = 2'd3
  } state_t;

  localparam logic [10:0] c_x_hidden = 11'h7FF;
  localparam logic [10:0] c_x_spawn  = 11'(H_SCREEN);
  localparam logic [10:0] c_y_min    = 11'(Y_MIN);
  localparam logic [7:0]  c_rsp_last = 8'(RESPAWN_FRAMES - 1);
  localparam logic [6:0]  c_ani_last = 7'(ANI_DIV - 1);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_ctrl;
  logic [15:0] r_pass_cnt, w_pass_nxt;
  logic        r_hit_flag, w_hit_flag_nxt;
  logic [15:0] r_lfsr;
  logic [7:0]  r_rcnt, w_rcnt_nxt;
  logic [6:0]  r_ani, w_ani_nxt;
  logic [10:0] r_x0, w_x0_nxt;
  logic [10:0] r_y0, w_y0_nxt;
  logic [1:0]  r_sid, w_sid_nxt;

  logic        w_en, w_auto, w_wr_ctrl, w_wr_clr, w_fb;
  logic [10:0] w_speed, w_y_off;
  logic        w_unused;

  assign w_en      = r_ctrl[0];
  assign w_auto    = r_ctrl[7];
  assign w_speed   = {7'd0, r_ctrl[4:1]};
  assign w_wr_ctrl = cs & write & (addr == 2'd0);
  assign w_wr_clr  = cs & write & (addr == 2'd2);
  assign w_fb      = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_y_off   = 11'(r_lfsr[Y_SPAN_BITS-1:0]);
  assign w_unused  = &{1'b0, read, wr_data[31:8]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ctrl     <= 8'd0;
      r_pass_cnt <= 16'd0;
      r_hit_flag <= 1'b0;
      r_lfsr     <= 16'hACE1;
      r_rcnt     <= 8'd0;
      r_ani      <= 7'd0;
      r_x0       <= c_x_hidden;
      r_y0       <= c_y_min;
      r_sid      <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_pass_cnt <= w_pass_nxt;
      r_hit_flag <= w_hit_flag_nxt;
      r_lfsr     <= {r_lfsr[14:0], w_fb};
      r_rcnt     <= w_rcnt_nxt;
      r_ani      <= w_ani_nxt;
      r_x0       <= w_x0_nxt;
      r_y0       <= w_y0_nxt;
      r_sid      <= w_sid_nxt;
      if (w_wr_ctrl) r_ctrl <= wr_data[7:0];
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pass_nxt     = r_pass_cnt;
    w_hit_flag_nxt = r_hit_flag;
    w_rcnt_nxt     = r_rcnt;
    w_ani_nxt      = r_ani;
    w_x0_nxt       = r_x0;
    w_y0_nxt       = r_y0;
    w_sid_nxt      = r_sid;

    case (r_state)
      S_IDLE: begin
        w_x0_nxt = c_x_hidden;
        if (w_en) begin
          w_state_nxt = S_RESPAWN;
          w_rcnt_nxt  = 8'd0;
        end
      end
      S_RESPAWN: begin
        if (frame_tick) begin
          if (r_rcnt == c_rsp_last) begin
            w_x0_nxt    = c_x_spawn;
            w_y0_nxt    = c_y_min + w_y_off;
            w_sid_nxt   = 2'd0;
            w_ani_nxt   = 7'd0;
            w_state_nxt = S_RUN;
          end else begin
            w_rcnt_nxt = r_rcnt + 8'd1;
          end
        end
      end
      S_RUN: begin
        // A collision in the same cycle as a tick suppresses the move.
        if (hit) begin
          w_state_nxt    = S_HIT;
          w_hit_flag_nxt = 1'b1;
        end else if (frame_tick) begin
          if (r_x0 < w_speed) begin
            w_x0_nxt    = c_x_hidden;
            w_state_nxt = S_RESPAWN;
            w_rcnt_nxt  = 8'd0;
            if (r_pass_cnt != 16'hFFFF) w_pass_nxt = r_pass_cnt + 16'd1;
          end else begin
            w_x0_nxt = r_x0 - w_speed;
          end
          if (w_auto) begin
            if (r_ani == c_ani_last) begin
              w_ani_nxt = 7'd0;
              w_sid_nxt = r_sid + 2'd1;
            end else begin
              w_ani_nxt = r_ani + 7'd1;
            end
          end
        end
      end
      S_HIT: begin
        if (w_wr_clr) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_wr_clr) begin
      w_hit_flag_nxt = 1'b0;
      if (wr_data[0]) w_pass_nxt = 16'd0;
    end

    // Disable overrides every other transition.
    if (!w_en) begin
      w_state_nxt = S_IDLE;
      w_x0_nxt    = c_x_hidden;
    end
  end

  always_comb begin
    rd_data = 32'd0;
    case (addr)
      2'd0: rd_data = {24'd0, r_ctrl};
      2'd1: rd_data = {13'd0, r_hit_flag, r_state, r_pass_cnt};
      2'd3: rd_data = {10'd0, r_y0, r_x0};
      default: rd_data = 32'd0;
    endcase
  end

  assign x0   = r_x0;
  assign y0   = r_y0;
  assign ctrl = {r_ctrl[6:5], r_ctrl[7], r_sid};

endmodule

`default_nettype wire

// File: tb/tb_obstacle_one_ctrl.sv
//==============================================================================
// Module      : tb_obstacle_one_ctrl
// Description : Directed self-checking bench for obstacle_one_ctrl.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_obstacle_one_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wr_data = 32'd0;
  logic [31:0] rd_data;
  logic        frame_tick = 1'b0;
  logic        hit = 1'b0;
  logic [10:0] x0, y0;
  logic [4:0]  ctrl;

  int checks = 0;
  int errors = 0;
  int exp_pass = 0;

  obstacle_one_ctrl dut (
    .clk(clk), .reset(reset), .cs(cs), .write(write), .read(read),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
    .frame_tick(frame_tick), .hit(hit), .x0(x0), .y0(y0), .ctrl(ctrl)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 frame_tick = 1'b1;
      @(posedge clk); #1 frame_tick = 1'b0;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1 cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    @(posedge clk); #1 cs = 1'b0; write = 1'b0; wr_data = 32'd0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1 d = rd_data;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    cyc(3);
    checks++; if (x0 !== 11'd2047) begin errors++; $display("FAIL reset_x0 got %0d want 2047", x0); end
    checks++; if (y0 !== 11'd400) begin errors++; $display("FAIL reset_y0 got %0d want 400", y0); end
    checks++; if (ctrl !== 5'd0) begin errors++; $display("FAIL reset_ctrl got %0h want 0", ctrl); end
    @(posedge clk); #1 reset = 1'b0;
    rd(2'd1, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_status got %0h want 0", d); end
    rd(2'd3, d);
    checks++; if (d !== {10'd0, 11'd400, 11'd2047}) begin errors++; $display("FAIL reset_pos got %0h want %0h", d, {10'd0, 11'd400, 11'd2047}); end
  endtask

  task automatic test_spawn_speed1();
    logic [31:0] d;
    wr(2'd0, 32'h03);
    cyc(2);
    tick_n(29);
    rd(2'd1, d);
    checks++; if (d[17:16] !== 2'd1) begin errors++; $display("FAIL respawn_29 state got %0d want 1", d[17:16]); end
    tick_n(1);
    rd(2'd1, d);
    checks++; if (d[17:16] !== 2'd2) begin errors++; $display("FAIL spawn_state got %0d want 2", d[17:16]); end
    checks++; if (x0 !== 11'd640) begin errors++; $display("FAIL spawn_x0 got %0d want 640", x0); end
    checks++; if (y0 < 11'd400 || y0 > 11'd463) begin errors++; $display("FAIL spawn_y0 got %0d want 400..463", y0); end
    tick_n(5);
    rd(2'd3, d);
    checks++; if (d[10:0] !== 11'd635) begin errors++; $display("FAIL move_speed1 got %0d want 635", d[10:0]); end
  endtask

  task automatic test_pass_speed15();
    logic [31:0] d;
    wr(2'd0, 32'h00);
    cyc(1);
    wr(2'd0, 32'h1F);
    cyc(2);
    tick_n(30);
    checks++; if (x0 !== 11'd640) begin errors++; $display("FAIL s15_spawn got %0d want 640", x0); end
    tick_n(42);
    checks++; if (x0 !== 11'd10) begin errors++; $display("FAIL s15_42 got %0d want 10", x0); end
    tick_n(1);
    exp_pass++;
    rd(2'd1, d);
    checks++; if (x0 !== 11'd2047) begin errors++; $display("FAIL s15_exit_x0 got %0d want 2047", x0); end
    checks++; if (d[17:0] !== {2'd1, 16'(exp_pass)}) begin errors++; $display("FAIL s15_exit_status got %0h want %0h", d[17:0], {2'd1, 16'(exp_pass)}); end
    tick_n(30);
    checks++; if (x0 !== 11'd640) begin errors++; $display("FAIL s15_respawn got %0d want 640", x0); end
  endtask

  task automatic test_exact_boundary();
    logic [31:0] d;
    wr(2'd0, 32'h11);
    tick_n(80);
    rd(2'd1, d);
    checks++; if (x0 !== 11'd0 || d[17:16] !== 2'd2) begin errors++; $display("FAIL exact_zero x0 %0d state %0d want 0 2", x0, d[17:16]); end
    tick_n(1);
    exp_pass++;
    rd(2'd1, d);
    checks++; if (x0 !== 11'd2047 || d[15:0] !== 16'(exp_pass)) begin errors++; $display("FAIL exact_exit x0 %0d pass %0d want 2047 %0d", x0, d[15:0], exp_pass); end
    tick_n(30);
  endtask

  task automatic test_hit();
    logic [31:0] d;
    tick_n(5);
    checks++; if (x0 !== 11'd600) begin errors++; $display("FAIL hit_pre got %0d want 600", x0); end
    @(posedge clk); #1 hit = 1'b1; frame_tick = 1'b1;
    @(posedge clk); #1 hit = 1'b0; frame_tick = 1'b0;
    rd(2'd1, d);
    checks++; if (x0 !== 11'd600) begin errors++; $display("FAIL hit_nomove got %0d want 600", x0); end
    checks++; if (d[18:16] !== 3'b111) begin errors++; $display("FAIL hit_status got %0b want 111", d[18:16]); end
    tick_n(2);
    checks++; if (x0 !== 11'd600) begin errors++; $display("FAIL hit_frozen got %0d want 600", x0); end
    wr(2'd2, 32'h0);
    rd(2'd1, d);
    checks++; if (d[18:0] !== {3'b010, 16'(exp_pass)}) begin errors++; $display("FAIL clear_status got %0h want %0h", d[18:0], {3'b010, 16'(exp_pass)}); end
    tick_n(1);
    checks++; if (x0 !== 11'd592) begin errors++; $display("FAIL after_clear got %0d want 592", x0); end
    hit = 1'b1;
    cyc(1);
    wr(2'd2, 32'h0);
    rd(2'd1, d);
    checks++; if (d[18:16] !== 3'b010) begin errors++; $display("FAIL clear_hit_high got %0b want 010", d[18:16]); end
    cyc(1);
    rd(2'd1, d);
    checks++; if (d[18:16] !== 3'b111) begin errors++; $display("FAIL rehit got %0b want 111", d[18:16]); end
    hit = 1'b0;
    wr(2'd2, 32'h0);
    @(posedge clk); #1 cs = 1'b1; write = 1'b1; addr = 2'd0; wr_data = 32'h03; frame_tick = 1'b1;
    @(posedge clk); #1 cs = 1'b0; write = 1'b0; wr_data = 32'd0; frame_tick = 1'b0;
    checks++; if (x0 !== 11'd584) begin errors++; $display("FAIL ctrl_tick_old_speed got %0d want 584", x0); end
    tick_n(1);
    checks++; if (x0 !== 11'd583) begin errors++; $display("FAIL ctrl_tick_new_speed got %0d want 583", x0); end
  endtask

  task automatic test_anim();
    logic [4:0] e;
    wr(2'd0, 32'h00);
    cyc(1);
    wr(2'd0, 32'hC3);
    cyc(2);
    tick_n(30);
    checks++; if (ctrl !== 5'h14) begin errors++; $display("FAIL anim_spawn got %0h want 14", ctrl); end
    for (int k = 1; k <= 5; k++) begin
      tick_n(7);
      e = 5'h14 | 5'((k - 1) % 4);
      checks++; if (ctrl !== e) begin errors++; $display("FAIL anim_hold%0d got %0h want %0h", k, ctrl, e); end
      tick_n(1);
      e = 5'h14 | 5'(k % 4);
      checks++; if (ctrl !== e) begin errors++; $display("FAIL anim_step%0d got %0h want %0h", k, ctrl, e); end
    end
    wr(2'd0, 32'h43);
    tick_n(16);
    checks++; if (ctrl !== 5'h11) begin errors++; $display("FAIL anim_off got %0h want 11", ctrl); end
  endtask

  task automatic test_disable();
    logic [31:0] d;
    wr(2'd0, 32'h00);
    cyc(1);
    rd(2'd1, d);
    checks++; if (x0 !== 11'd2047 || d[17:16] !== 2'd0) begin errors++; $display("FAIL disable x0 %0d state %0d want 2047 0", x0, d[17:16]); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    wr(2'd0, 32'hC3);
    cyc(2);
    tick_n(10);
    rd(2'd1, d);
    checks++; if (d[17:16] !== 2'd1) begin errors++; $display("FAIL mid_state got %0d want 1", d[17:16]); end
    #1 reset = 1'b1;
    #1;
    checks++; if (x0 !== 11'd2047 || y0 !== 11'd400 || ctrl !== 5'd0) begin errors++; $display("FAIL async_reset_out x0 %0d y0 %0d ctrl %0h want 2047 400 0", x0, y0, ctrl); end
    rd(2'd1, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL async_reset_status got %0h want 0", d); end
    rd(2'd0, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL async_reset_ctrlreg got %0h want 0", d); end
    checks++; if (dut.r_lfsr !== 16'hACE1) begin errors++; $display("FAIL async_reset_lfsr got %0h want ace1", dut.r_lfsr); end
    @(posedge clk); #1 reset = 1'b0;
    exp_pass = 0;
  endtask

  task automatic test_saturation();
    logic [31:0] d;
    wr(2'd0, 32'h1F);
    cyc(2);
    tick_n(30);
    force dut.r_pass_cnt = 16'hFFFE;
    cyc(1);
    release dut.r_pass_cnt;
    tick_n(43);
    rd(2'd1, d);
    checks++; if (d[17:0] !== {2'd1, 16'hFFFF}) begin errors++; $display("FAIL sat_reach got %0h want %0h", d[17:0], {2'd1, 16'hFFFF}); end
    tick_n(73);
    rd(2'd1, d);
    checks++; if (d[17:0] !== {2'd1, 16'hFFFF}) begin errors++; $display("FAIL sat_hold got %0h want %0h", d[17:0], {2'd1, 16'hFFFF}); end
    wr(2'd2, 32'h1);
    rd(2'd1, d);
    checks++; if (d[15:0] !== 16'd0) begin errors++; $display("FAIL clear_pass got %0h want 0", d[15:0]); end
  endtask

  initial begin
    test_reset();
    test_spawn_speed1();
    test_pass_speed15();
    test_exact_boundary();
    test_hit();
    test_anim();
    test_disable();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
